// File: rtl/spi_clk_gen_if.sv
// -----------------------------------------------------------------------------
// spi_clk_gen_if
//
// Bundles the control inputs and clock outputs of the SPI clock generator so
// that the transfer controller and the generator share one port.
//
//   enable     master -> slave  module enable
//   go         master -> slave  transfer request; clock runs while go & enable
//   CPOL       master -> slave  idle level of clk_out
//   last_clk   master -> slave  current SPI clock is the last of a character
//   divider_i  master -> slave  half-period length minus 1, in sysclk cycles
//   clk_out    slave -> master  registered SPI serial clock
//   pos_edge   slave -> master  one-cycle pulse with clk_out going 0->1
//   neg_edge   slave -> master  one-cycle pulse with clk_out going 1->0
// -----------------------------------------------------------------------------
interface spi_clk_gen_if #(
    parameter int N = 8
);
    logic         enable;
    logic         go;
    logic         CPOL;
    logic         last_clk;
    logic [N-1:0] divider_i;
    logic         clk_out;
    logic         pos_edge;
    logic         neg_edge;

    // The transfer controller drives the requests and observes the clock.
    modport master (
        output enable,
        output go,
        output CPOL,
        output last_clk,
        output divider_i,
        input  clk_out,
        input  pos_edge,
        input  neg_edge
    );

    // The clock generator consumes the requests and produces the clock.
    modport slave (
        input  enable,
        input  go,
        input  CPOL,
        input  last_clk,
        input  divider_i,
        output clk_out,
        output pos_edge,
        output neg_edge
    );
endinterface

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
//
// Programmable SPI serial-clock generator. A half-period down-counter divides
// sysclk; every time it expires clk_out toggles and a one-cycle pos_edge or
// neg_edge strobe is produced alongside it, so the shift logic can sample and
// launch data on the same cycle the clock edge appears.
//
// Ports:
//   sysclk     system clock, all state changes on its rising edge
//   rst_n      asynchronous reset, ACTIVE-HIGH (legacy name)
//   bus        spi_clk_gen_if.slave:
//                enable, go, CPOL, last_clk, divider_i  (inputs)
//                clk_out, pos_edge, neg_edge            (registered outputs)
//
// Timing: SPI period = 2*(divider_i+1) sysclk cycles. The first edge appears
// divider_i+1 cycles after the clock starts running and always leaves the
// CPOL idle level. divider_i is only sampled when the counter reloads.
// -----------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int N = 8
) (
    input  logic        sysclk,
    input  logic        rst_n,
    spi_clk_gen_if.slave bus
);

    logic [N-1:0] cnt_q,      cnt_d;
    logic         stopped_q,  stopped_d;
    logic         clk_out_q,  clk_out_d;
    logic         pos_edge_q, pos_edge_d;
    logic         neg_edge_q, neg_edge_d;

    logic         run;
    logic         toggle;

    // stopped blocks the clock after the final edge of a character until the
    // controller drops go or enable, so a held-high go cannot start a new
    // character on its own.
    assign run    = bus.enable & bus.go & ~stopped_q;
    assign toggle = run & (cnt_q == '0);

    always_comb begin
        cnt_d      = cnt_q;
        clk_out_d  = clk_out_q;
        pos_edge_d = 1'b0;
        neg_edge_d = 1'b0;
        stopped_d  = stopped_q;

        if (!run) begin
            // Idle: park at the idle level and keep the counter primed so the
            // first half-period is a full divider_i+1 cycles, and any partial
            // half-period in progress is abandoned without a strobe.
            cnt_d     = bus.divider_i;
            clk_out_d = bus.CPOL;
        end else if (toggle) begin
            clk_out_d  = ~clk_out_q;
            cnt_d      = bus.divider_i;
            pos_edge_d = ~clk_out_q;
            neg_edge_d = clk_out_q;
        end else begin
            cnt_d = cnt_q - N'(1);
        end

        // An edge that lands back on the idle level closes an SPI clock; if it
        // was flagged as the last one, the character is complete.
        if (!bus.enable || !bus.go) begin
            stopped_d = 1'b0;
        end else if (toggle && (clk_out_d == bus.CPOL) && bus.last_clk) begin
            stopped_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q      <= '0;
            stopped_q  <= 1'b0;
            clk_out_q  <= 1'b0;
            pos_edge_q <= 1'b0;
            neg_edge_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            stopped_q  <= stopped_d;
            clk_out_q  <= clk_out_d;
            pos_edge_q <= pos_edge_d;
            neg_edge_q <= neg_edge_d;
        end
    end

    assign bus.clk_out  = clk_out_q;
    assign bus.pos_edge = pos_edge_q;
    assign bus.neg_edge = neg_edge_q;

endmodule

// File: tb/tb_spi_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_clk_gen
//
// Bench for spi_clk_gen. A timestamp-based reference model predicts clk_out,
// pos_edge and neg_edge each cycle; a compare process checks them on every
// falling sysclk edge. Directed sequences add hand-computed literal checks.
// Inputs change 2 time units after each rising sysclk edge.
// -----------------------------------------------------------------------------
module tb_spi_clk_gen;
    localparam int N = 8;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b1;

    spi_clk_gen_if #(.N(N)) bus ();

    spi_clk_gen #(.N(N)) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int vectors = 0;
    int errors  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instead of a counter it keeps the absolute cycle index
    // at which the next toggle is due. Idle cycles re-arm it divider_i+1 ahead.
    int   t      = 0;
    int   m_next = 0;
    logic m_clk  = 1'b0;
    logic m_pe   = 1'b0;
    logic m_ne   = 1'b0;
    logic m_stop = 1'b0;

    always @(posedge sysclk or posedge rst_n) begin
        bit m_run;
        bit m_tog;
        if (rst_n) begin
            m_clk  = 1'b0;
            m_pe   = 1'b0;
            m_ne   = 1'b0;
            m_stop = 1'b0;
            m_next = t;
        end else begin
            m_run = bus.enable && bus.go && !m_stop;
            m_tog = m_run && (t == m_next);
            m_pe  = 1'b0;
            m_ne  = 1'b0;
            if (!m_run) begin
                m_clk  = bus.CPOL;
                m_next = t + 1 + int'(bus.divider_i);
            end else if (m_tog) begin
                m_pe   = !m_clk;
                m_ne   = m_clk;
                m_clk  = !m_clk;
                m_next = t + 1 + int'(bus.divider_i);
            end
            if (!bus.enable || !bus.go)
                m_stop = 1'b0;
            else if (m_tog && (m_clk == bus.CPOL) && bus.last_clk)
                m_stop = 1'b1;
            t++;
        end
    end

    always @(negedge sysclk) begin
        if (cmp_en) begin
            chk("clk_out",  32'(bus.clk_out),  32'(m_clk));
            chk("pos_edge", 32'(bus.pos_edge), 32'(m_pe));
            chk("neg_edge", 32'(bus.neg_edge), 32'(m_ne));
            chk("edge_excl", 32'(bus.pos_edge & bus.neg_edge), 32'd0);
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #2;
    endtask

    // Cycles until clk_out reaches lvl, bounded; returns 999 on timeout.
    task automatic wait_level(input logic lvl, output int n);
        n = 999;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.clk_out === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int pe_cnt;
        int ne_cnt;

        bus.enable    = 1'b0;
        bus.go        = 1'b0;
        bus.CPOL      = 1'b0;
        bus.last_clk  = 1'b0;
        bus.divider_i = 8'd4;

        // Reset state
        repeat (3) tick();
        chk("rst_clk_out",  32'(bus.clk_out),  32'd0);
        chk("rst_pos_edge", 32'(bus.pos_edge), 32'd0);
        chk("rst_neg_edge", 32'(bus.neg_edge), 32'd0);
        cmp_en = 1'b1;
        rst_n  = 1'b0;
        tick();
        chk("idle_cpol0", 32'(bus.clk_out), 32'd0);
        bus.CPOL = 1'b1;
        tick();
        chk("idle_follow_cpol1", 32'(bus.clk_out), 32'd1);
        bus.CPOL = 1'b0;
        tick();

        // CPOL=0, divider 4: first rise 5 cycles after go, 8+8 pulses per 80
        bus.enable = 1'b1;
        bus.go     = 1'b1;
        wait_level(1'b1, n);
        chk("cpol0_first_rise_cycles", 32'(n), 32'd5);
        chk("cpol0_first_pos_edge", 32'(bus.pos_edge), 32'd1);
        pe_cnt = 0;
        ne_cnt = 0;
        repeat (80) begin
            tick();
            pe_cnt += int'(bus.pos_edge);
            ne_cnt += int'(bus.neg_edge);
        end
        chk("cpol0_pos_per_80", 32'(pe_cnt), 32'd8);
        chk("cpol0_neg_per_80", 32'(ne_cnt), 32'd8);
        bus.go = 1'b0;
        tick();
        chk("go_drop_idle", 32'(bus.clk_out), 32'd0);
        chk("go_drop_no_neg", 32'(bus.neg_edge), 32'd0);

        // CPOL=1: idles high, first edge falls
        bus.CPOL = 1'b1;
        repeat (2) tick();
        chk("cpol1_idle", 32'(bus.clk_out), 32'd1);
        bus.go = 1'b1;
        wait_level(1'b0, n);
        chk("cpol1_first_fall_cycles", 32'(n), 32'd5);
        chk("cpol1_first_neg_edge", 32'(bus.neg_edge), 32'd1);
        repeat (30) tick();
        bus.go = 1'b0;
        tick();
        bus.CPOL = 1'b0;
        tick();

        // divider 0: toggles every cycle
        bus.divider_i = 8'd0;
        tick();
        bus.go = 1'b1;
        tick();
        chk("div0_first_edge", 32'(bus.clk_out), 32'd1);
        n = 0;
        repeat (10) begin
            tick();
            n += int'(bus.pos_edge) + int'(bus.neg_edge);
        end
        chk("div0_pulses_per_10", 32'(n), 32'd10);
        bus.go = 1'b0;
        tick();

        // divider change mid-run takes effect at the next reload
        bus.divider_i = 8'd3;
        tick();
        bus.go = 1'b1;
        repeat (13) tick();
        bus.divider_i = 8'd1;
        repeat (12) tick();
        bus.go = 1'b0;
        tick();

        // last_clk: stop after the 8th falling edge, then restart
        bus.go = 1'b1;
        ne_cnt = 0;
        for (int i = 0; i < 200 && ne_cnt < 7; i++) begin
            tick();
            ne_cnt += int'(bus.neg_edge);
        end
        chk("lastclk_seven_neg", 32'(ne_cnt), 32'd7);
        bus.last_clk = 1'b1;
        pe_cnt = 0;
        ne_cnt = 0;
        repeat (30) begin
            tick();
            pe_cnt += int'(bus.pos_edge);
            ne_cnt += int'(bus.neg_edge);
        end
        chk("lastclk_final_pos", 32'(pe_cnt), 32'd1);
        chk("lastclk_final_neg", 32'(ne_cnt), 32'd1);
        chk("lastclk_parked", 32'(bus.clk_out), 32'd0);
        bus.last_clk = 1'b0;
        bus.go = 1'b0;
        tick();
        bus.go = 1'b1;
        wait_level(1'b1, n);
        chk("restart_first_rise_cycles", 32'(n), 32'd2);
        bus.go = 1'b0;
        tick();

        // enable dropped mid-half-period
        bus.divider_i = 8'd4;
        tick();
        bus.go = 1'b1;
        wait_level(1'b1, n);
        chk("en_drop_rise_cycles", 32'(n), 32'd5);
        repeat (2) tick();
        bus.enable = 1'b0;
        tick();
        chk("en_drop_idle", 32'(bus.clk_out), 32'd0);
        chk("en_drop_no_neg", 32'(bus.neg_edge), 32'd0);
        bus.enable = 1'b1;

        // reset mid-transfer is immediate
        wait_level(1'b1, n);
        chk("pre_rst_rise_cycles", 32'(n), 32'd5);
        tick();
        rst_n = 1'b1;
        #1;
        chk("async_rst_clk_out",  32'(bus.clk_out),  32'd0);
        chk("async_rst_pos_edge", 32'(bus.pos_edge), 32'd0);
        chk("async_rst_neg_edge", 32'(bus.neg_edge), 32'd0);
        bus.CPOL = 1'b1;
        bus.go   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("post_rst_cpol1", 32'(bus.clk_out), 32'd1);
        tick();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
